// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS-style front end.
// Imported by the fetch stage and its PC register.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OPC_HALT  = 6'b111111;

    typedef enum logic {
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

    // Byte PC to ROM word index, keeping only the low `width` bits.
    function automatic logic [31:0] pc_to_word(
        input logic [31:0] pc,
        input int unsigned width
    );
        logic [31:0] mask;
        mask = (32'h1 << width) - 32'h1;
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC,
// loads d only when en is high.
import mips_pkg::*;

module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Hold the PC unless a new value is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, next-PC select, halt FSM
// and the IF/ID pipeline register.
import mips_pkg::*;

module instr_fetch #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = OPC_HALT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    input  logic                  jump,
    input  logic [31:0]           jump_target,
    output logic [31:0]           pc,
    output logic [DATA_WIDTH-1:0] ifid_instr,
    output logic [31:0]           ifid_pc_plus4,
    output logic                  ifid_valid,
    output logic                  halted
);

    fetch_state_t state;

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        redirect;
    logic        halt_hit;
    logic        is_halted;

    logic        sel_jump;
    logic        sel_branch;
    logic        sel_hold;
    logic        sel_inc;

    assign rom_addr  = ADDR_WIDTH'(pc_to_word(pc, ADDR_WIDTH));
    assign pc_plus4  = pc + 32'd4;
    assign redirect  = jump | branch_taken;
    assign is_halted = (state == FS_HALTED);

    // A halt word only counts when it is really being
    // consumed: not stalled, not squashed, not redirected.
    assign halt_hit = (state == FS_RUN) & ~stall & ~flush &
                      ~redirect &
                      (rom_q[31:26] == HALT_OPCODE);

    // One-hot selects so the decoder below stays exclusive
    // even when jump and branch arrive together.
    assign sel_jump   = jump;
    assign sel_branch = branch_taken & ~jump;
    assign sel_hold   = ~redirect &
                        (stall | is_halted | halt_hit);
    assign sel_inc    = ~redirect & ~sel_hold;

    // Next-PC select, jump over branch over hold over +4.
    always_comb begin
        pc_next = pc;
        pc_en   = 1'b0;
        unique case (1'b1)
            sel_jump: begin
                pc_next = jump_target & ~32'h3;
                pc_en   = 1'b1;
            end
            sel_branch: begin
                pc_next = branch_target & ~32'h3;
                pc_en   = 1'b1;
            end
            sel_hold: begin
                pc_next = pc;
                pc_en   = 1'b0;
            end
            sel_inc: begin
                pc_next = pc_plus4;
                pc_en   = 1'b1;
            end
            default: begin
                pc_next = pc;
                pc_en   = 1'b0;
            end
        endcase
    end

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk(clk),
        .rst(rst),
        .en (pc_en),
        .d  (pc_next),
        .q  (pc)
    );

    // Fetch FSM; halted mirrors the state as a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FS_RUN;
            halted <= 1'b0;
        end else begin
            unique case (state)
                FS_RUN: begin
                    if (halt_hit) begin
                        state  <= FS_HALTED;
                        halted <= 1'b1;
                    end
                end
                FS_HALTED: begin
                    if (redirect) begin
                        state  <= FS_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= FS_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush over stall over halt bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_instr    <= DATA_WIDTH'(NOP_INSTR);
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else if (flush) begin
            ifid_instr    <= DATA_WIDTH'(NOP_INSTR);
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else if (stall) begin
            ifid_instr    <= ifid_instr;
            ifid_pc_plus4 <= ifid_pc_plus4;
            ifid_valid    <= ifid_valid;
        end else if (is_halted) begin
            ifid_instr    <= DATA_WIDTH'(NOP_INSTR);
            ifid_valid    <= 1'b0;
        end else begin
            ifid_instr    <= rom_q;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

endmodule
